// File: rtl/enet_pkg.sv
// Shared definitions for the ENET RX queue configuration bank: register index map,
// CTRL bit positions, the per-queue config record and the shadow-write clamp helpers.
package enet_pkg;

  localparam int RSFL_IDX = 0;
  localparam int RSEM_IDX = 1;
  localparam int RAFL_IDX = 2;
  localparam int RAEM_IDX = 3;
  localparam int FTRL_IDX = 4;
  localparam int RDSR_IDX = 5;
  localparam int CTRL_IDX = 6;
  localparam int RSVD_IDX = 7;
  localparam int NUM_IDX  = 8;

  localparam int CTRL_COMMIT_BIT  = 0;
  localparam int CTRL_DISCARD_BIT = 1;

  localparam logic [7:0] RAEM_MIN = 8'd4;

  typedef enum logic {Q_IDLE, Q_PEND} qstate_t;

  typedef struct packed {
    logic [7:0]  rsfl;
    logic [4:0]  rsem_stat;
    logic [7:0]  rsem_rx;
    logic [7:0]  rafl;
    logic [7:0]  raem;
    logic [13:0] ftrl;
    logic [31:0] rdsr;
  } qcfg_t;

  // Level thresholds stay DEPTH-4 below full; FIFOs deeper than 256 just saturate the 8-bit field.
  function automatic logic [7:0] level_bound(input int fifo_aw);
    if (fifo_aw <= 8) return 8'((1 << fifo_aw) - 4);
    return 8'hff;
  endfunction

  function automatic logic [7:0] clamp_max(input logic [7:0] v, input logic [7:0] bound);
    return (v > bound) ? bound : v;
  endfunction

  function automatic logic [7:0] clamp_rsfl(input logic [7:0] v, input logic [7:0] bound);
    return (v == 8'd0) ? 8'd0 : clamp_max(v, bound);
  endfunction

  function automatic logic [7:0] clamp_raem(input logic [7:0] v);
    return (v < RAEM_MIN) ? RAEM_MIN : v;
  endfunction

  function automatic qcfg_t cfg_reset(input int fifo_aw, input logic [13:0] ftrl_rst);
    qcfg_t c;
    c      = '0;
    c.rafl = level_bound(fifo_aw);
    c.raem = RAEM_MIN;
    c.ftrl = ftrl_rst;
    return c;
  endfunction

endpackage

// File: rtl/FF_D_with_wen.sv
// Generic D register with write enable and asynchronous active-low reset to a parameterised value.
module FF_D_with_wen #(
  parameter int           W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wen,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST;
    else if (wen) q <= d;
  end

endmodule

// File: rtl/enet_rx_qcfg_slot.sv
// One RX queue's configuration slot: clamped shadow copy, atomically committed active copy,
// IDLE/PEND commit FSM and the registered FIFO-level flags.
module enet_rx_qcfg_slot
  import enet_pkg::*;
#(
  parameter int          FIFO_AW  = 7,
  parameter logic [13:0] FTRL_RST = 14'h7ff
) (
  input  logic                    rx_clk,
  input  logic                    rst_n,
  input  logic [CTRL_IDX:0]       wsel,
  input  logic [31:0]             wdata,
  input  logic                    rx_idle,
  input  logic [FIFO_AW:0]        level,
  output logic [NUM_IDX*32-1:0]   rd_words,
  output logic [7:0]              rsfl,
  output logic [4:0]              rsem_stat,
  output logic [7:0]              rsem_rx,
  output logic [7:0]              rafl,
  output logic [7:0]              raem,
  output logic [13:0]             ftrl,
  output logic [31:0]             rdsr,
  output logic                    cfg_pending,
  output logic                    cfg_applied,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    sect_full
);

  localparam logic [7:0]    BOUND   = level_bound(FIFO_AW);
  localparam qcfg_t         CFG_RST = cfg_reset(FIFO_AW, FTRL_RST);
  localparam int            CW      = (FIFO_AW + 2 > 9) ? FIFO_AW + 2 : 9;
  localparam logic [CW-1:0] DEPTH_C = CW'(2 ** FIFO_AW);

  qcfg_t         shadow, shadow_d, active_q;
  logic          shadow_wen, commit, discard, apply;
  qstate_t       state, state_d;
  logic          applied_q, af_q, ae_q, sf_q;
  logic [CW-1:0] lvl;

  // DISCARD dominates COMMIT when both bits arrive in one write.
  assign discard    = wsel[CTRL_IDX] & wdata[CTRL_DISCARD_BIT];
  assign commit     = wsel[CTRL_IDX] & wdata[CTRL_COMMIT_BIT] & ~wdata[CTRL_DISCARD_BIT];
  assign shadow_wen = (|wsel[RDSR_IDX:RSFL_IDX]) | discard;

  always_comb begin
    shadow_d = shadow;
    if (wsel[RSFL_IDX]) shadow_d.rsfl = clamp_rsfl(wdata[7:0], BOUND);
    if (wsel[RSEM_IDX]) begin
      shadow_d.rsem_stat = wdata[20:16];
      shadow_d.rsem_rx   = wdata[7:0];
    end
    if (wsel[RAFL_IDX]) shadow_d.rafl = clamp_max(wdata[7:0], BOUND);
    if (wsel[RAEM_IDX]) shadow_d.raem = clamp_raem(wdata[7:0]);
    if (wsel[FTRL_IDX]) shadow_d.ftrl = wdata[13:0];
    if (wsel[RDSR_IDX]) shadow_d.rdsr = {wdata[31:3], 3'b000};
    if (discard)        shadow_d = active_q;
  end

  FF_D_with_wen #(.W($bits(qcfg_t)), .RST(CFG_RST)) u_shadow (
    .clk(rx_clk), .rst_n(rst_n), .wen(shadow_wen), .d(shadow_d), .q(shadow)
  );

  // Active copy samples the shadow as it stood before any same-cycle shadow write.
  FF_D_with_wen #(.W($bits(qcfg_t)), .RST(CFG_RST)) u_active (
    .clk(rx_clk), .rst_n(rst_n), .wen(apply), .d(shadow), .q(active_q)
  );

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= Q_IDLE;
      applied_q <= 1'b0;
    end else begin
      state     <= state_d;
      applied_q <= apply;
    end
  end

  always_comb begin
    state_d = state;
    apply   = 1'b0;
    case (state)
      Q_IDLE: if (commit) state_d = Q_PEND;
      Q_PEND: begin
        if (!discard && rx_idle) begin
          apply   = 1'b1;
          state_d = Q_IDLE;
        end
      end
      default: state_d = Q_IDLE;
    endcase
    if (discard) state_d = Q_IDLE;
  end

  assign lvl = CW'(level);

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      af_q <= 1'b0;
      ae_q <= 1'b0;
      sf_q <= 1'b0;
    end else begin
      af_q <= lvl >= (DEPTH_C - CW'(active_q.rafl));
      ae_q <= lvl <= CW'(active_q.raem);
      sf_q <= (active_q.rsfl != 8'd0) && (lvl >= CW'(active_q.rsfl));
    end
  end

  always_comb begin
    rd_words = '0;
    rd_words[RSFL_IDX*32 +: 32] = {24'd0, shadow.rsfl};
    rd_words[RSEM_IDX*32 +: 32] = {11'd0, shadow.rsem_stat, 8'd0, shadow.rsem_rx};
    rd_words[RAFL_IDX*32 +: 32] = {24'd0, shadow.rafl};
    rd_words[RAEM_IDX*32 +: 32] = {24'd0, shadow.raem};
    rd_words[FTRL_IDX*32 +: 32] = {18'd0, shadow.ftrl};
    rd_words[RDSR_IDX*32 +: 32] = shadow.rdsr;
    rd_words[CTRL_IDX*32 +: 32] = {31'd0, cfg_pending};
  end

  assign cfg_pending  = (state == Q_PEND);
  assign cfg_applied  = applied_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign sect_full    = sf_q;
  assign rsfl         = active_q.rsfl;
  assign rsem_stat    = active_q.rsem_stat;
  assign rsem_rx      = active_q.rsem_rx;
  assign rafl         = active_q.rafl;
  assign raem         = active_q.raem;
  assign ftrl         = active_q.ftrl;
  assign rdsr         = active_q.rdsr;

endmodule

// File: rtl/enet_rx_queue_cfg_reg.sv
// Multi-queue ENET RX threshold/config register bank: address decode to per-queue slots
// and a registered read mux over the shadow values.
module enet_rx_queue_cfg_reg
  import enet_pkg::*;
#(
  parameter int          NUM_Q    = 2,
  parameter int          FIFO_AW  = 7,
  parameter logic [13:0] FTRL_RST = 14'h7ff,
  localparam int         QW       = (NUM_Q > 1) ? $clog2(NUM_Q) : 1,
  localparam int         ADDR_W   = QW + 3
) (
  input  logic                       rx_clk,
  input  logic                       rst_n,
  input  logic                       reg_wen,
  input  logic [ADDR_W-1:0]          reg_waddr,
  input  logic [31:0]                reg_wdata,
  input  logic [ADDR_W-1:0]          reg_raddr,
  output logic [31:0]                reg_rdata,
  input  logic [NUM_Q-1:0]           rx_idle,
  input  logic [NUM_Q*(FIFO_AW+1)-1:0] rx_fifo_level,
  output logic [NUM_Q*8-1:0]         rsfl,
  output logic [NUM_Q*5-1:0]         rsem_stat,
  output logic [NUM_Q*8-1:0]         rsem_rx,
  output logic [NUM_Q*8-1:0]         rafl,
  output logic [NUM_Q*8-1:0]         raem,
  output logic [NUM_Q*14-1:0]        ftrl,
  output logic [NUM_Q*32-1:0]        rdsr,
  output logic [NUM_Q-1:0]           cfg_pending,
  output logic [NUM_Q-1:0]           cfg_applied,
  output logic [NUM_Q-1:0]           almost_full,
  output logic [NUM_Q-1:0]           almost_empty,
  output logic [NUM_Q-1:0]           sect_full
);

  logic [QW-1:0]           wq, rq;
  logic [2:0]              widx, ridx;
  logic [NUM_IDX*32-1:0]   slot_words [NUM_Q];
  logic [31:0]             rdata_d;

  assign wq   = reg_waddr[ADDR_W-1:3];
  assign widx = reg_waddr[2:0];
  assign rq   = reg_raddr[ADDR_W-1:3];
  assign ridx = reg_raddr[2:0];

  // Queues beyond NUM_Q have no slot, so their writes fall away and reads stay zero.
  for (genvar g = 0; g < NUM_Q; g++) begin : g_slot
    logic [CTRL_IDX:0] wsel;

    always_comb begin
      wsel = '0;
      for (int i = 0; i <= CTRL_IDX; i++)
        wsel[i] = reg_wen && (wq == QW'(g)) && (widx == 3'(i));
    end

    enet_rx_qcfg_slot #(.FIFO_AW(FIFO_AW), .FTRL_RST(FTRL_RST)) u_slot (
      .rx_clk       (rx_clk),
      .rst_n        (rst_n),
      .wsel         (wsel),
      .wdata        (reg_wdata),
      .rx_idle      (rx_idle[g]),
      .level        (rx_fifo_level[g*(FIFO_AW+1) +: FIFO_AW+1]),
      .rd_words     (slot_words[g]),
      .rsfl         (rsfl[g*8 +: 8]),
      .rsem_stat    (rsem_stat[g*5 +: 5]),
      .rsem_rx      (rsem_rx[g*8 +: 8]),
      .rafl         (rafl[g*8 +: 8]),
      .raem         (raem[g*8 +: 8]),
      .ftrl         (ftrl[g*14 +: 14]),
      .rdsr         (rdsr[g*32 +: 32]),
      .cfg_pending  (cfg_pending[g]),
      .cfg_applied  (cfg_applied[g]),
      .almost_full  (almost_full[g]),
      .almost_empty (almost_empty[g]),
      .sect_full    (sect_full[g])
    );
  end

  always_comb begin
    rdata_d = '0;
    for (int q = 0; q < NUM_Q; q++)
      if (rq == QW'(q)) rdata_d = slot_words[q][ridx*32 +: 32];
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) reg_rdata <= '0;
    else        reg_rdata <= rdata_d;
  end

endmodule

// File: tb/tb_enet_rx_queue_cfg_reg.sv
// Directed scoreboard bench for enet_rx_queue_cfg_reg (NUM_Q=2, FIFO_AW=7, DEPTH=128).
module tb_enet_rx_queue_cfg_reg;

  localparam int NUM_Q   = 2;
  localparam int FIFO_AW = 7;
  localparam int LW      = FIFO_AW + 1;
  localparam int ADDR_W  = 4;

  localparam int I_RSFL = 0, I_RSEM = 1, I_RAFL = 2, I_RAEM = 3;
  localparam int I_FTRL = 4, I_RDSR = 5, I_CTRL = 6, I_RSVD = 7;

  logic                  rx_clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  reg_wen = 1'b0;
  logic [ADDR_W-1:0]     reg_waddr = '0;
  logic [31:0]           reg_wdata = '0;
  logic [ADDR_W-1:0]     reg_raddr = '0;
  logic [31:0]           reg_rdata;
  logic [NUM_Q-1:0]      rx_idle = '0;
  logic [NUM_Q*LW-1:0]   rx_fifo_level = '0;
  logic [NUM_Q*8-1:0]    rsfl, rsem_rx, rafl, raem;
  logic [NUM_Q*5-1:0]    rsem_stat;
  logic [NUM_Q*14-1:0]   ftrl;
  logic [NUM_Q*32-1:0]   rdsr;
  logic [NUM_Q-1:0]      cfg_pending, cfg_applied, almost_full, almost_empty, sect_full;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   applied_cnt [NUM_Q];
  int   base;

  enet_rx_queue_cfg_reg #(.NUM_Q(NUM_Q), .FIFO_AW(FIFO_AW), .FTRL_RST(14'h7ff)) dut (
    .rx_clk(rx_clk), .rst_n(rst_n),
    .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .rx_idle(rx_idle), .rx_fifo_level(rx_fifo_level),
    .rsfl(rsfl), .rsem_stat(rsem_stat), .rsem_rx(rsem_rx), .rafl(rafl), .raem(raem),
    .ftrl(ftrl), .rdsr(rdsr),
    .cfg_pending(cfg_pending), .cfg_applied(cfg_applied),
    .almost_full(almost_full), .almost_empty(almost_empty), .sect_full(sect_full)
  );

  always #5 rx_clk = ~rx_clk;

  initial for (int q = 0; q < NUM_Q; q++) applied_cnt[q] = 0;

  always @(posedge rx_clk)
    for (int q = 0; q < NUM_Q; q++)
      if (cfg_applied[q] === 1'b1) applied_cnt[q] = applied_cnt[q] + 1;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge rx_clk);
    #1;
  endtask

  task automatic pushExpected(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=%h expected=none", observed);
      return;
    end
    e = sb.pop_front();
    assert (observed === e.exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.exp);
    end
  endtask

  task automatic applyStimulus(input int q, input int idx, input logic [31:0] data);
    reg_wen   = 1'b1;
    reg_waddr = ADDR_W'(q * 8 + idx);
    reg_wdata = data;
    tick();
    reg_wen   = 1'b0;
  endtask

  task automatic readReg(input int q, input int idx, input logic [31:0] exp, input string tag);
    reg_raddr = ADDR_W'(q * 8 + idx);
    pushExpected(tag, exp);
    tick();
    checkOutput(reg_rdata);
  endtask

  function automatic logic [31:0] activeField(input int q, input int idx);
    case (idx)
      I_RSFL:  return 32'(rsfl[q*8 +: 8]);
      I_RAFL:  return 32'(rafl[q*8 +: 8]);
      I_RAEM:  return 32'(raem[q*8 +: 8]);
      I_FTRL:  return 32'(ftrl[q*14 +: 14]);
      I_RDSR:  return rdsr[q*32 +: 32];
      default: return {11'd0, rsem_stat[q*5 +: 5], 8'd0, rsem_rx[q*8 +: 8]};
    endcase
  endfunction

  task automatic checkActive(input int q, input int idx, input logic [31:0] exp, input string tag);
    pushExpected(tag, exp);
    checkOutput(activeField(q, idx));
  endtask

  task automatic checkBit(input logic observed, input logic exp, input string tag);
    pushExpected(tag, 32'(exp));
    checkOutput(32'(observed));
  endtask

  task automatic checkFlags(input int q, input int level, input logic [2:0] exp, input string tag);
    rx_fifo_level[q*LW +: LW] = LW'(level);
    pushExpected(tag, 32'(exp));
    tick();
    checkOutput(32'({almost_full[q], almost_empty[q], sect_full[q]}));
  endtask

  initial begin
    // Reset values while rst_n is still held low
    tick(2);
    for (int q = 0; q < NUM_Q; q++) begin
      checkActive(q, I_RAFL, 32'd124, $sformatf("rst_rafl_q%0d", q));
      checkActive(q, I_RAEM, 32'd4, $sformatf("rst_raem_q%0d", q));
      checkActive(q, I_FTRL, 32'h7ff, $sformatf("rst_ftrl_q%0d", q));
      checkActive(q, I_RSFL, 32'd0, $sformatf("rst_rsfl_q%0d", q));
      checkActive(q, I_RDSR, 32'd0, $sformatf("rst_rdsr_q%0d", q));
      pushExpected($sformatf("rst_flags_q%0d", q), 32'd0);
      checkOutput(32'({almost_full[q], almost_empty[q], sect_full[q]}));
      checkBit(cfg_pending[q], 1'b0, $sformatf("rst_pending_q%0d", q));
    end
    pushExpected("rst_rdata", 32'd0);
    checkOutput(reg_rdata);
    rst_n = 1'b1;
    tick();

    // Shadow write clamps and read-back
    applyStimulus(1, I_RAFL, 32'd200);
    readReg(1, I_RAFL, 32'd124, "q1_rafl_clamp");
    applyStimulus(1, I_RAEM, 32'd1);
    readReg(1, I_RAEM, 32'd4, "q1_raem_clamp");
    applyStimulus(1, I_RDSR, 32'hFFFF_FFFF);
    readReg(1, I_RDSR, 32'hFFFF_FFF8, "q1_rdsr_low_bits");
    applyStimulus(1, I_RSFL, 32'd200);
    readReg(1, I_RSFL, 32'd124, "q1_rsfl_clamp");
    applyStimulus(1, I_RSEM, 32'hFFFF_FFAB);
    readReg(1, I_RSEM, 32'h001F_00AB, "q1_rsem_fields");
    applyStimulus(1, I_FTRL, 32'hFFFF_C123);
    readReg(1, I_FTRL, 32'h0000_0123, "q1_ftrl_width");
    applyStimulus(1, I_RSVD, 32'hFFFF_FFFF);
    readReg(1, I_RSVD, 32'd0, "q1_reserved_read");
    readReg(0, I_RAFL, 32'd124, "q0_shadow_untouched");
    checkActive(1, I_RDSR, 32'd0, "q1_active_rdsr_no_commit");
    checkActive(0, I_RAFL, 32'd124, "q0_active_rafl");

    // Commit held off by a frame in progress, applied once rx_idle rises
    applyStimulus(0, I_RSFL, 32'h40);
    base = applied_cnt[0];
    applyStimulus(0, I_CTRL, 32'h1);
    checkBit(cfg_pending[0], 1'b1, "q0_pending_after_commit");
    tick(4);
    checkBit(cfg_pending[0], 1'b1, "q0_pending_held");
    checkActive(0, I_RSFL, 32'd0, "q0_rsfl_not_applied");
    readReg(0, I_CTRL, 32'd1, "q0_ctrl_read_pending");
    rx_idle[0] = 1'b1;
    tick();
    checkActive(0, I_RSFL, 32'h40, "q0_rsfl_applied");
    checkBit(cfg_applied[0], 1'b1, "q0_applied_pulse");
    rx_idle[0] = 1'b0;
    tick();
    checkBit(cfg_applied[0], 1'b0, "q0_applied_single");
    checkBit(cfg_pending[0], 1'b0, "q0_pending_cleared");
    pushExpected("q0_applied_count", 32'd1);
    checkOutput(32'(applied_cnt[0] - base));

    // Shadow write landing in the apply cycle
    applyStimulus(0, I_FTRL, 32'h200);
    applyStimulus(0, I_CTRL, 32'h1);
    rx_idle[0] = 1'b1;
    applyStimulus(0, I_FTRL, 32'h100);
    checkActive(0, I_FTRL, 32'h200, "q0_ftrl_pre_write_shadow");
    checkBit(cfg_applied[0], 1'b1, "q0_applied_apply_cycle");
    readReg(0, I_FTRL, 32'h100, "q0_ftrl_shadow_kept");
    applyStimulus(0, I_CTRL, 32'h1);
    checkBit(cfg_pending[0], 1'b1, "q0_pending_n1");
    checkBit(cfg_applied[0], 1'b0, "q0_not_applied_n1");
    checkActive(0, I_FTRL, 32'h200, "q0_ftrl_n1");
    tick();
    checkActive(0, I_FTRL, 32'h100, "q0_ftrl_n2");
    checkBit(cfg_applied[0], 1'b1, "q0_applied_n2");
    rx_idle[0] = 1'b0;

    // DISCARD restores the shadow from the active set
    rx_idle[1] = 1'b1;
    base = applied_cnt[1];
    applyStimulus(1, I_CTRL, 32'h3);
    checkBit(cfg_pending[1], 1'b0, "q1_discard_wins");
    tick(2);
    pushExpected("q1_discard_no_pulse", 32'd0);
    checkOutput(32'(applied_cnt[1] - base));
    checkActive(1, I_RDSR, 32'd0, "q1_active_rdsr_kept");
    readReg(1, I_RDSR, 32'd0, "q1_shadow_rdsr_restored");
    readReg(1, I_RSFL, 32'd0, "q1_shadow_rsfl_restored");
    rx_idle[1] = 1'b0;
    applyStimulus(1, I_RDSR, 32'h1234_5678);
    applyStimulus(1, I_CTRL, 32'h1);
    checkBit(cfg_pending[1], 1'b1, "q1_pending");
    applyStimulus(1, I_CTRL, 32'h2);
    checkBit(cfg_pending[1], 1'b0, "q1_discard_from_pend");
    base = applied_cnt[1];
    rx_idle[1] = 1'b1;
    tick(3);
    checkActive(1, I_RDSR, 32'd0, "q1_rdsr_not_applied");
    pushExpected("q1_pend_discard_no_pulse", 32'd0);
    checkOutput(32'(applied_cnt[1] - base));
    readReg(1, I_RDSR, 32'd0, "q1_rdsr_shadow_restored");
    rx_idle[1] = 1'b0;

    // Level flags {almost_full, almost_empty, sect_full} with rafl=124, raem=4, rsfl=0x40
    checkFlags(0, 3,   3'b010, "flags_lvl3");
    checkFlags(0, 4,   3'b110, "flags_lvl4");
    checkFlags(0, 5,   3'b100, "flags_lvl5");
    checkFlags(0, 63,  3'b100, "flags_lvl63");
    checkFlags(0, 64,  3'b101, "flags_lvl64");
    applyStimulus(0, I_RAFL, 32'd8);
    rx_idle[0] = 1'b1;
    applyStimulus(0, I_CTRL, 32'h1);
    tick();
    rx_idle[0] = 1'b0;
    checkActive(0, I_RAFL, 32'd8, "q0_rafl8_applied");
    checkFlags(0, 119, 3'b001, "flags_rafl8_lvl119");
    checkFlags(0, 120, 3'b101, "flags_rafl8_lvl120");
    checkFlags(0, 128, 3'b101, "flags_rafl8_lvl128");

    // Reset while a commit is pending
    applyStimulus(1, I_RSFL, 32'h10);
    applyStimulus(1, I_CTRL, 32'h1);
    checkBit(cfg_pending[1], 1'b1, "q1_pending_before_reset");
    #2;
    rst_n = 1'b0;
    #1;
    checkBit(cfg_pending[1], 1'b0, "q1_pending_async_reset");
    checkActive(1, I_RSFL, 32'd0, "q1_rsfl_async_reset");
    tick();
    rst_n = 1'b1;
    base = applied_cnt[1];
    rx_idle = '1;
    tick(3);
    checkBit(cfg_pending[1], 1'b0, "q1_no_pending_after_reset");
    checkActive(1, I_RSFL, 32'd0, "q1_rsfl_no_apply");
    pushExpected("q1_no_pulse_after_reset", 32'd0);
    checkOutput(32'(applied_cnt[1] - base));
    readReg(1, I_RSFL, 32'd0, "q1_shadow_rsfl_reset");
    readReg(1, I_FTRL, 32'h7ff, "q1_shadow_ftrl_reset");
    rx_idle = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
